memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result (address or writeback value), the store data and the control bits; performs loads and stores over a ready/request data-memory bus; registers the writeback result for the write-back stage.
- Multi-cycle memory accesses stall the upstream pipeline via `stall`.
- Handles byte/half/word lane placement, load sign/zero extension and bus timeout.

---
 rtl/memory_stage.sv | 203 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: load/store pipeline stage; 1-cycle pass-through, >=2-cycle memory ops, stall holds upstream mid-access.
// Optional MISALIGN_CHECK_EN: misaligned H/W accesses complete without a bus request and pulse misalign_err.
module memory_stage #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        bus_err,
    output logic        misalign_err
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int   CW      = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam int   TO_LAST = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
    localparam logic TO_EN   = (BUS_TIMEOUT > 0);

    state_t         state, state_nxt;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic           we_q;
    logic [2:0]     funct3_q;
    logic [4:0]     rd_q;
    logic           reg_write_q;
    logic [CW-1:0]  cnt;

    logic           mem_op;
    logic           misal;
    logic           accept;
    logic           done;
    logic           abort;
    logic [3:0]     be_new;
    logic [31:0]    wdata_new;
    logic [31:0]    load_ext;
    logic [7:0]     lb;
    logic [15:0]    lh;

    assign mem_op = in_valid & (mem_read | mem_write);

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        misal = 1'b0;
        case (funct3[1:0])
            2'b00:   misal = 1'b0;
            2'b01:   misal = alu_data[0];
            default: misal = |alu_data[1:0];
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    // Size decode shares funct3[1:0] for loads and stores; bit 2 only selects zero-extension.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = memory_data;
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << alu_data[1:0];
                wdata_new = {4{memory_data[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {alu_data[1], 1'b0};
                wdata_new = {2{memory_data[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = memory_data;
            end
        endcase
    end

    always_comb begin
        lb       = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lh       = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{lb[7]}}, lb};
            3'b100:  load_ext = {24'b0, lb};
            3'b001:  load_ext = {{16{lh[15]}}, lh};
            3'b101:  load_ext = {16'b0, lh};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !misal) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (TO_EN && cnt == CW'(TO_LAST)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stall drops in the completing/aborting cycle so upstream advances in lockstep with the FSM.
    assign stall = mem_op & ~((state == IDLE) & misal) & ~done & ~abort;

    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            if (accept) begin
                addr_q       <= alu_data;
                wdata_q      <= wdata_new;
                be_q         <= be_new;
                we_q         <= mem_write;
                funct3_q     <= funct3;
                rd_q         <= rd;
                reg_write_q  <= reg_write;
                cnt          <= '0;
                out_valid    <= 1'b0;
                wb_reg_write <= 1'b0;
            end else if (state == IDLE) begin
                out_valid    <= in_valid;
                wb_data      <= alu_data;
                wb_rd        <= rd;
                wb_reg_write <= reg_write & in_valid;
                if (mem_op && misal) begin
                    wb_data      <= '0;
                    wb_reg_write <= 1'b0;
                    misalign_err <= 1'b1;
                end
            end else if (done) begin
                out_valid    <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= reg_write_q & ~we_q;
                wb_data      <= we_q ? 32'b0 : load_ext;
            end else if (abort) begin
                out_valid    <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= 1'b0;
                wb_data      <= '0;
                bus_err      <= 1'b1;
            end else begin
                out_valid    <= 1'b0;
                wb_reg_write <= 1'b0;
                cnt          <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table of single ops plus wait-state, timeout, reset and misalign sequences.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_data;
    logic [31:0] memory_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        bus_err;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_stage #(.BUS_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_data(alu_data),
        .memory_data(memory_data), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .rd(rd), .reg_write(reg_write), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .bus_err(bus_err),
        .misalign_err(misalign_err)
    );

    typedef struct {
        logic        is_mem;
        logic [31:0] alu;
        logic [31:0] mdat;
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic        e_rw;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] md, input logic r, input logic w,
                            input logic [2:0] f, input logic [4:0] d, input logic rw);
        in_valid    = 1'b1;
        alu_data    = a;
        memory_data = md;
        mem_read    = r;
        mem_write   = w;
        funct3      = f;
        rd          = d;
        reg_write   = rw;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
    endtask

    // Entered and left at posedge+1; a zero-wait bus answers in the first ACCESS cycle.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        drive_op(v.alu, v.mdat, v.rd_en, v.wr_en, v.f3, v.rd, v.rw);
        dmem_ready = 1'b0;
        #1;
        chk1({t, ".stall_accept"}, stall, v.is_mem);
        chk1({t, ".req_accept"}, dmem_req, 1'b0);
        if (v.is_mem) begin
            @(posedge clk); #1;
            chk1({t, ".req"}, dmem_req, 1'b1);
            chk({t, ".addr"}, dmem_addr, v.e_addr);
            chk({t, ".be"}, 32'(dmem_be), 32'(v.e_be));
            chk1({t, ".we"}, dmem_we, v.wr_en);
            if (v.wr_en) chk({t, ".wdata"}, dmem_wdata, v.e_wdata);
            chk1({t, ".ov_access"}, out_valid, 1'b0);
            dmem_ready = 1'b1;
            dmem_rdata = v.rdata;
            #1;
            chk1({t, ".stall_done"}, stall, 1'b0);
        end
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h5A5A_0F0F;
        idle_inputs();
        chk1({t, ".out_valid"}, out_valid, 1'b1);
        chk({t, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk1({t, ".wb_reg_write"}, wb_reg_write, v.e_rw);
        if (!(v.is_mem && v.wr_en)) chk({t, ".wb_data"}, wb_data, v.e_wb);
        chk1({t, ".req_after"}, dmem_req, 1'b0);
        chk1({t, ".misalign_err"}, misalign_err, 1'b0);
    endtask

    initial begin
        // is_mem, alu, mdat, rd_en, wr_en, f3, rd, rw, rdata, e_addr, e_be, e_wdata, e_wb, e_rw
        vecs[0]  = '{1'b0, 32'h0000_1234, 32'h0,         1'b0, 1'b0, 3'b000, 5'd5,  1'b1, 32'h0,         32'h0,      4'b0000, 32'h0,         32'h0000_1234, 1'b1};
        vecs[1]  = '{1'b0, 32'hDEAD_BEEF, 32'h11,        1'b0, 1'b0, 3'b010, 5'd7,  1'b0, 32'h0,         32'h0,      4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_1003, 32'h0,         1'b1, 1'b0, 3'b000, 5'd3,  1'b1, 32'h80FF_FF00, 32'h1000,   4'b1000, 32'h0,         32'hFFFF_FF80, 1'b1};
        vecs[3]  = '{1'b1, 32'h0000_1003, 32'h0,         1'b1, 1'b0, 3'b100, 5'd4,  1'b1, 32'h80FF_FF00, 32'h1000,   4'b1000, 32'h0,         32'h0000_0080, 1'b1};
        vecs[4]  = '{1'b1, 32'h0000_1002, 32'h0,         1'b1, 1'b0, 3'b001, 5'd6,  1'b1, 32'h8001_7FFF, 32'h1000,   4'b1100, 32'h0,         32'hFFFF_8001, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_1000, 32'h0,         1'b1, 1'b0, 3'b101, 5'd8,  1'b1, 32'h8001_F00D, 32'h1000,   4'b0011, 32'h0,         32'h0000_F00D, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_2000, 32'h0,         1'b1, 1'b0, 3'b010, 5'd9,  1'b1, 32'h1234_5678, 32'h2000,   4'b1111, 32'h0,         32'h1234_5678, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_4001, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 5'd10, 1'b1, 32'h0,         32'h4000,   4'b0010, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'h0000_4004, 32'hCAFE_F00D, 1'b0, 1'b1, 3'b010, 5'd11, 1'b0, 32'h0,         32'h4004,   4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[9]  = '{1'b1, 32'h0000_4002, 32'h1234_563C, 1'b0, 1'b1, 3'b100, 5'd12, 1'b1, 32'h0,         32'h4000,   4'b0100, 32'h3C3C_3C3C, 32'h0,         1'b0};
        vecs[10] = '{1'b1, 32'h0000_5000, 32'h0,         1'b1, 1'b0, 3'b011, 5'd13, 1'b1, 32'h8765_4321, 32'h5000,   4'b1111, 32'h0,         32'h8765_4321, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_1001, 32'h0,         1'b1, 1'b0, 3'b000, 5'd14, 1'b1, 32'h0000_7F00, 32'h1000,   4'b0010, 32'h0,         32'h0000_007F, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_2004, 32'h0,         1'b1, 1'b0, 3'b010, 5'd15, 1'b0, 32'hAAAA_5555, 32'h2004,   4'b1111, 32'h0,         32'hAAAA_5555, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_4002, 32'h0000_BEEF, 1'b0, 1'b1, 3'b101, 5'd16, 1'b1, 32'h0,         32'h4000,   4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0};

        reset       = 1'b1;
        alu_data    = '0;
        memory_data = '0;
        funct3      = '0;
        rd          = '0;
        dmem_ready  = 1'b0;
        dmem_rdata  = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk1("rst.req", dmem_req, 1'b0);
        chk1("rst.out_valid", out_valid, 1'b0);
        chk1("rst.stall", stall, 1'b0);
        chk("rst.wb_data", wb_data, 32'h0);
        chk1("rst.wb_reg_write", wb_reg_write, 1'b0);
        chk1("rst.bus_err", bus_err, 1'b0);
        chk1("rst.misalign_err", misalign_err, 1'b0);
        chk("rst.addr", dmem_addr, 32'h0);
        reset = 1'b0;

        // Vectors run back-to-back: each op is accepted in the IDLE cycle after the previous completion.
        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Store half with three wait states: bus signals must hold for all four request cycles.
        drive_op(32'h0000_2002, 32'hAAAA_BEEF, 1'b0, 1'b1, 3'b001, 5'd18, 1'b0);
        #1;
        chk1("sh.stall_accept", stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk1($sformatf("sh.req%0d", i), dmem_req, 1'b1);
            chk($sformatf("sh.addr%0d", i), dmem_addr, 32'h0000_2000);
            chk($sformatf("sh.be%0d", i), 32'(dmem_be), 32'h0000_000C);
            chk($sformatf("sh.wdata%0d", i), dmem_wdata, 32'hBEEF_BEEF);
            chk1($sformatf("sh.we%0d", i), dmem_we, 1'b1);
            chk1($sformatf("sh.ov%0d", i), out_valid, 1'b0);
            if (i == 3) dmem_ready = 1'b1;
            #1;
            chk1($sformatf("sh.stall%0d", i), stall, i != 3);
        end
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        idle_inputs();
        chk1("sh.out_valid", out_valid, 1'b1);
        chk1("sh.wb_reg_write", wb_reg_write, 1'b0);
        chk1("sh.req_after", dmem_req, 1'b0);

        // Load with a silent bus: 16 request cycles, then abort with a bus_err pulse.
        drive_op(32'h0000_6000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd17, 1'b1);
        dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk1("to.stall_accept", stall, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk1($sformatf("to.req%0d", i), dmem_req, 1'b1);
            chk1($sformatf("to.stall%0d", i), stall, i != 15);
            chk1($sformatf("to.bus_err%0d", i), bus_err, 1'b0);
        end
        @(posedge clk); #1;
        idle_inputs();
        chk1("to.req_dropped", dmem_req, 1'b0);
        chk1("to.bus_err", bus_err, 1'b1);
        chk1("to.out_valid", out_valid, 1'b1);
        chk1("to.wb_reg_write", wb_reg_write, 1'b0);
        chk("to.wb_data", wb_data, 32'h0);
        @(posedge clk); #1;
        chk1("to.bus_err_pulse", bus_err, 1'b0);
        chk1("to.out_valid_after", out_valid, 1'b0);

        // Reset in the second ACCESS cycle drops the access; the next load runs normally.
        drive_op(32'h0000_7000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd19, 1'b1);
        @(posedge clk); #1;
        chk1("rs.req_c1", dmem_req, 1'b1);
        @(posedge clk); #1;
        chk1("rs.req_c2", dmem_req, 1'b1);
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        chk1("rs.req", dmem_req, 1'b0);
        chk1("rs.out_valid", out_valid, 1'b0);
        chk1("rs.wb_reg_write", wb_reg_write, 1'b0);
        chk1("rs.bus_err", bus_err, 1'b0);
        reset = 1'b0;
        run_vec(vecs[6], 100);

        // Misaligned word load at 0x3001.
`ifdef MISALIGN_CHECK_EN
        drive_op(32'h0000_3001, 32'h0, 1'b1, 1'b0, 3'b010, 5'd20, 1'b1);
        #1;
        chk1("ma.stall", stall, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        chk1("ma.req", dmem_req, 1'b0);
        chk1("ma.misalign_err", misalign_err, 1'b1);
        chk1("ma.out_valid", out_valid, 1'b1);
        chk1("ma.wb_reg_write", wb_reg_write, 1'b0);
        @(posedge clk); #1;
        chk1("ma.misalign_pulse", misalign_err, 1'b0);
        chk1("ma.req_after", dmem_req, 1'b0);
`else
        begin
            vec_t mv;
            mv = '{1'b1, 32'h0000_3001, 32'h0, 1'b1, 1'b0, 3'b010, 5'd20, 1'b1,
                   32'hFEED_FACE, 32'h3000, 4'b1111, 32'h0, 32'hFEED_FACE, 1'b1};
            run_vec(mv, 200);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
